uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- 8-bit UART transmitter: the stage directly upstream of the UART receiver on the serial line.
- Serializes one byte per request onto o_TX_Serial: start bit, data LSB-first, optional parity, then stop bit(s).
- Targets the 100 MHz Nexys Artix-7 clock at 115200 baud by default.
- Intended use: board-level echo/loopback, with o_TX_Serial driving the PC RX line or the receiver's i_Rx_serial.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per serial bit (100 MHz / 115200); legal range >= 2.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- i_clk  input  1  system clock; all logic on the rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_TX_DV  input  1  byte-valid strobe; accepted only when o_TX_Ready = 1.
- i_TX_Byte  input  8  byte to transmit; sampled on the accept edge.
- o_TX_Ready  output  1  high while in IDLE; request may be accepted.
- o_TX_Active  output  1  high from the first start-bit cycle through the last stop-bit cycle.
- o_TX_Serial  output  1  serial line; idles high.
- o_TX_Done  output  1  one-cycle pulse after a frame completes.

Behaviour:
- Interface: one clock (i_clk); reset i_rst is synchronous and active-high.
- Reset:
  - While i_rst = 1 at a clock edge: state = IDLE, o_TX_Serial = 1, o_TX_Active = 0, o_TX_Done = 0, counters = 0.
  - i_TX_DV is ignored while i_rst = 1.
  - Reset mid-frame aborts the frame at once; the line returns high on the next edge. No Done pulse is generated.
- o_TX_Ready = (state == IDLE) && !i_rst; this output is combinational.
- Accept: an edge with i_TX_DV & o_TX_Ready latches i_TX_Byte into the shift register and moves to START.
  - On the following cycle o_TX_Serial = 0 and o_TX_Active = 1.
  - i_TX_DV while not ready is dropped; no queuing.
- States and transitions (each bit state holds for exactly CLKS_PER_BIT cycles, counted 0..CLKS_PER_BIT-1):
  - IDLE: line high. On accept -> START.
  - START: line 0 -> DATA.
  - DATA: line = data[idx], with idx 0..7. Increment idx at each bit end. After idx 7 -> PARITY if PARITY != 0, else STOP.
  - PARITY: line = ^data for even parity, ~^data for odd parity -> STOP.
  - STOP: line 1 for STOP_BITS bit periods -> IDLE.
- Done and back-to-back:
  - o_TX_Done = 1 for exactly the first cycle back in IDLE; o_TX_Active = 0 in that cycle.
  - A new request in the Done cycle is accepted, giving back-to-back frames with no extra idle cycles.
- Frame length: exactly CLKS_PER_BIT*(1 + 8 + (PARITY != 0) + STOP_BITS) cycles from the first start-bit cycle to the Done cycle.
- Output timing: o_TX_Serial is registered, so there are no combinational glitches on the line.
- Widths:
  - Bit counter width is $clog2(CLKS_PER_BIT) and it wraps to 0 at each bit boundary.
  - Bit index is 3 bits; stop counter is 1 bit.
- Latched byte: it is held for the entire frame. Changes on i_TX_Byte after accept have no effect.

Decomposition:
- Package uart_pkg holds:
  - state encoding (IDLE, START, DATA, PARITY, STOP);
  - parity encodings PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2;
  - default CLKS_PER_BIT = 868.
- One natural sub-module: uart_baud_counter.
  - Parameter CLKS_PER_BIT.
  - Inputs i_clk, i_rst, i_clear.
  - Output o_bit_end, high in the last cycle of each bit period.
  - The same counter is reusable by the receiver.

Test Plan:
- Reset mid-frame: assert i_rst at cycle 3000 of a frame -> o_TX_Serial = 1 on the next edge, o_TX_Active = 0, no Done pulse, o_TX_Ready = 1 once reset releases.
- Basic 8N1 (CLKS_PER_BIT = 868): send 0x56 -> line low for 868 cycles, then 0,1,1,0,1,0,1,0 at 868 cycles each, then high. o_TX_Done pulses exactly 8680 cycles after the first start-bit cycle.
- Loopback: wire o_TX_Serial to the UART receiver, send 0x56 then 0x48 back-to-back (second i_TX_DV in the Done cycle) -> receiver outputs 0x56 then 0x48. No idle gap between the stop bit and the second start bit.
- Parity (CLKS_PER_BIT = 4):
  - PARITY = 1, send 0x56 (four ones) -> parity bit 0; frame is 44 cycles.
  - PARITY = 2, send 0x48 -> parity bit 1.
- Two stop bits (STOP_BITS = 2, CLKS_PER_BIT = 4): send 0xFF -> line high for 8 cycles after the last data bit; Done fires at cycle 44.
- Busy drop: pulse i_TX_DV with 0xAA during an active frame carrying 0x11 -> 0xAA is never transmitted, 0x11 completes intact, and only one Done pulse occurs.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, parity encodings and defaults
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int DEFAULT_CLKS_PER_BIT = 868;

  // Even parity makes the total count of ones even; odd parity makes it odd.
  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PAR_ODD) ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte request / serial line bundle for the UART transmitter
interface uart_tx_if;

  logic       i_TX_DV;
  logic [7:0] i_TX_Byte;
  logic       o_TX_Ready;
  logic       o_TX_Active;
  logic       o_TX_Serial;
  logic       o_TX_Done;

  modport master (
    output i_TX_DV, i_TX_Byte,
    input  o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done
  );

  modport slave (
    input  i_TX_DV, i_TX_Byte,
    output o_TX_Ready, o_TX_Active, o_TX_Serial, o_TX_Done
  );

endinterface

// File: rtl/uart_baud_counter.sv
// rtl/uart_baud_counter.sv - bit-period counter shared by UART transmit and receive
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign o_bit_end = (cnt == LAST);

  // Count 0..CLKS_PER_BIT-1 and wrap; held at zero while cleared so a new bit starts aligned.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear || o_bit_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter with optional parity and 1 or 2 stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PAR_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  uart_tx_if.slave  tx
);

  tx_state_t  state, next_state;
  logic [7:0] data_q;
  logic [2:0] idx, idx_d;
  logic       stop_cnt, stop_d;
  logic       serial_q, line_d;
  logic       done_q, done_d;
  logic       bit_end;
  logic       ready;
  logic       accept;

  assign ready  = (state == ST_IDLE) && !i_rst;
  assign accept = tx.i_TX_DV && ready;

  assign tx.o_TX_Ready  = ready;
  assign tx.o_TX_Active = (state != ST_IDLE);
  assign tx.o_TX_Serial = serial_q;
  assign tx.o_TX_Done   = done_q;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (state == ST_IDLE),
    .o_bit_end(bit_end)
  );

  // State register; reset aborts any frame in progress.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Datapath registers; the line value is registered so it never glitches.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q   <= 8'h00;
      idx      <= 3'd0;
      stop_cnt <= 1'b0;
      serial_q <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      if (accept) begin
        data_q <= tx.i_TX_Byte;
      end
      idx      <= idx_d;
      stop_cnt <= stop_d;
      serial_q <= line_d;
      done_q   <= done_d;
    end
  end

  // Next state, and the line level for the state being entered next cycle.
  always_comb begin
    next_state = state;
    idx_d      = idx;
    stop_d     = 1'b0;
    line_d     = 1'b1;
    done_d     = 1'b0;
    case (state)
      ST_IDLE: begin
        idx_d = 3'd0;
        if (accept) next_state = ST_START;
      end
      ST_START: begin
        if (bit_end) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          idx_d = idx + 3'd1;
          if (idx == 3'd7) begin
            next_state = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) next_state = ST_STOP;
      end
      ST_STOP: begin
        stop_d = stop_cnt;
        if (bit_end) begin
          if ((STOP_BITS == 1) || (stop_cnt == 1'b1)) begin
            next_state = ST_IDLE;
            done_d     = 1'b1;
            stop_d     = 1'b0;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase

    case (next_state)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = data_q[idx_d];
      ST_PARITY: line_d = parity_bit(data_q, PARITY);
      default:   line_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed self-checking bench for uart_tx
module tb_uart_tx;
  import uart_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt_a = 0;

  always #5 clk = ~clk;

  uart_tx_if a_if ();
  uart_tx_if e_if ();
  uart_tx_if o_if ();
  uart_tx_if s_if ();

  uart_tx #(.CLKS_PER_BIT(868), .PARITY(PAR_NONE), .STOP_BITS(1)) u_a (.i_clk(clk), .i_rst(rst), .tx(a_if));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY(PAR_EVEN), .STOP_BITS(1)) u_e (.i_clk(clk), .i_rst(rst), .tx(e_if));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY(PAR_ODD), .STOP_BITS(1)) u_o (.i_clk(clk), .i_rst(rst), .tx(o_if));
  uart_tx #(.CLKS_PER_BIT(4), .PARITY(PAR_NONE), .STOP_BITS(2)) u_s (.i_clk(clk), .i_rst(rst), .tx(s_if));

  // Count every Done pulse on the 8N1 instance.
  always @(posedge clk) begin
    if (a_if.o_TX_Done === 1'b1) done_cnt_a <= done_cnt_a + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called in the first start-bit cycle of a frame on u_a; samples each bit at its centre.
  task automatic rx_a(input bit inject, output logic [7:0] b, output logic st, output logic sp,
                      output logic d_early, output logic d_at);
    b = 8'h00;
    tick(434);
    st = a_if.o_TX_Serial;
    for (int i = 0; i < 8; i++) begin
      if (inject && i == 3) begin
        a_if.i_TX_DV = 1'b1;
        a_if.i_TX_Byte = 8'hAA;
        tick(1);
        a_if.i_TX_DV = 1'b0;
        a_if.i_TX_Byte = 8'h00;
        tick(867);
      end else begin
        tick(868);
      end
      b[i] = a_if.o_TX_Serial;
    end
    tick(868);
    sp = a_if.o_TX_Serial;
    tick(433);
    d_early = a_if.o_TX_Done;
    tick(1);
    d_at = a_if.o_TX_Done;
  endtask

  logic [47:0] we, wo, ws, de, dn_o, ds;
  logic [7:0]  eb, ob, sb, rb;
  logic        st, sp, d_early, d_at, low_seen;
  int          dc0;

  initial begin
    a_if.i_TX_DV = 1'b0; a_if.i_TX_Byte = 8'h00;
    e_if.i_TX_DV = 1'b0; e_if.i_TX_Byte = 8'h00;
    o_if.i_TX_DV = 1'b0; o_if.i_TX_Byte = 8'h00;
    s_if.i_TX_DV = 1'b0; s_if.i_TX_Byte = 8'h00;

    // Reset state
    tick(3);
    check("rst_serial", a_if.o_TX_Serial, 1);
    check("rst_active", a_if.o_TX_Active, 0);
    check("rst_done", a_if.o_TX_Done, 0);
    check("rst_ready", a_if.o_TX_Ready, 0);
    rst = 1'b0;
    tick(1);
    check("idle_ready_a", a_if.o_TX_Ready, 1);
    check("idle_ready_e", e_if.o_TX_Ready, 1);

    // Parity and two-stop frames at 4 clocks per bit
    e_if.i_TX_DV = 1'b1; e_if.i_TX_Byte = 8'h56;
    o_if.i_TX_DV = 1'b1; o_if.i_TX_Byte = 8'h48;
    s_if.i_TX_DV = 1'b1; s_if.i_TX_Byte = 8'hFF;
    tick(1);
    e_if.i_TX_DV = 1'b0; e_if.i_TX_Byte = 8'h00;
    o_if.i_TX_DV = 1'b0; o_if.i_TX_Byte = 8'h00;
    s_if.i_TX_DV = 1'b0; s_if.i_TX_Byte = 8'h00;
    for (int t = 0; t < 48; t++) begin
      we[t] = e_if.o_TX_Serial; de[t] = e_if.o_TX_Done;
      wo[t] = o_if.o_TX_Serial; dn_o[t] = o_if.o_TX_Done;
      ws[t] = s_if.o_TX_Serial; ds[t] = s_if.o_TX_Done;
      tick(1);
    end
    for (int i = 0; i < 8; i++) begin
      eb[i] = we[4 * (i + 1) + 2];
      ob[i] = wo[4 * (i + 1) + 2];
      sb[i] = ws[4 * (i + 1) + 2];
    end
    check("even_start", we[2], 0);
    check("even_data", eb, 8'h56);
    check("even_parity", we[38], 0);
    check("even_stop", we[42], 1);
    check("even_done_early", de[43], 0);
    check("even_done_44", de[44], 1);
    check("odd_data", ob, 8'h48);
    check("odd_parity", wo[38], 1);
    check("odd_done_44", dn_o[44], 1);
    check("two_stop_start", ws[3:0], 4'h0);
    check("two_stop_data", sb, 8'hFF);
    check("two_stop_high", ws[43:36], 8'hFF);
    check("two_stop_done_early", ds[43], 0);
    check("two_stop_done_44", ds[44], 1);
    check("post_ready_o", o_if.o_TX_Ready, 1);
    check("post_active_s", s_if.o_TX_Active, 0);

    // Basic 8N1 at 868 clocks per bit, byte changed right after accept
    a_if.i_TX_DV = 1'b1; a_if.i_TX_Byte = 8'h56;
    tick(1);
    a_if.i_TX_DV = 1'b0; a_if.i_TX_Byte = 8'h00;
    check("a_first_serial", a_if.o_TX_Serial, 0);
    check("a_first_active", a_if.o_TX_Active, 1);
    check("a_first_ready", a_if.o_TX_Ready, 0);
    rx_a(1'b0, rb, st, sp, d_early, d_at);
    check("a56_start", st, 0);
    check("a56_data", rb, 8'h56);
    check("a56_stop", sp, 1);
    check("a56_done_early", d_early, 0);
    check("a56_done_8680", d_at, 1);
    check("a56_done_active", a_if.o_TX_Active, 0);

    // Back-to-back request in the Done cycle
    a_if.i_TX_DV = 1'b1; a_if.i_TX_Byte = 8'h48;
    tick(1);
    a_if.i_TX_DV = 1'b0; a_if.i_TX_Byte = 8'h00;
    check("b2b_no_gap", a_if.o_TX_Serial, 0);
    check("b2b_active", a_if.o_TX_Active, 1);
    rx_a(1'b0, rb, st, sp, d_early, d_at);
    check("a48_data", rb, 8'h48);
    check("a48_stop", sp, 1);
    check("a48_done_8680", d_at, 1);
    tick(2);
    dc0 = done_cnt_a;

    // Busy drop: 0xAA offered mid-frame of 0x11
    a_if.i_TX_DV = 1'b1; a_if.i_TX_Byte = 8'h11;
    tick(1);
    a_if.i_TX_DV = 1'b0; a_if.i_TX_Byte = 8'h00;
    rx_a(1'b1, rb, st, sp, d_early, d_at);
    check("busy_data", rb, 8'h11);
    check("busy_done", d_at, 1);
    low_seen = 1'b0;
    for (int t = 0; t < 900; t++) begin
      if (a_if.o_TX_Serial !== 1'b1) low_seen = 1'b1;
      tick(1);
    end
    check("busy_no_second_frame", low_seen, 0);
    check("busy_one_done", done_cnt_a - dc0, 1);

    // Reset mid-frame at cycle 3000
    a_if.i_TX_DV = 1'b1; a_if.i_TX_Byte = 8'h00;
    tick(1);
    a_if.i_TX_DV = 1'b0;
    dc0 = done_cnt_a;
    tick(2999);
    check("midrst_before", a_if.o_TX_Active, 1);
    rst = 1'b1;
    tick(1);
    check("midrst_serial", a_if.o_TX_Serial, 1);
    check("midrst_active", a_if.o_TX_Active, 0);
    check("midrst_done", a_if.o_TX_Done, 0);
    check("midrst_ready_in_rst", a_if.o_TX_Ready, 0);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", a_if.o_TX_Ready, 1);
    tick(20);
    check("midrst_no_done", done_cnt_a - dc0, 0);
    check("midrst_line_idle", a_if.o_TX_Serial, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
